asl8_seq: RTL and testbench
===========================

Name: asl8_seq

Overview:
- Sequential arithmetic shift-left unit. It is the left-direction companion to the team's 8-bit combinational arithmetic right shifter.
- Shifts a captured operand left by one bit per clock under a small FSM. A down-counter tracks the remaining shift amount.
- Uses a start/busy/done handshake and reports signed overflow.
- Sits in the shifter/counter datapath wherever a multi-cycle, area-cheap left shift is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- SHAMT_W, 3, shift-amount width; legal shift range is 0..2^SHAMT_W-1.

Ports:
- clk  input  1  single clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled on rising clk.
- d_in  input  WIDTH  operand, captured when start is accepted.
- shamt  input  SHAMT_W  shift amount, captured when start is accepted.
- d_out  output  WIDTH  result register.
- busy  output  1  high while shifting.
- done  output  1  one-cycle completion pulse.
- ovf  output  1  signed-overflow flag for the last operation.

Behaviour:
- Reset: reset_n low immediately forces d_out=0, busy=0, done=0, ovf=0, counter=0, state=IDLE. It takes effect regardless of clk and aborts any operation in flight.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: done=1, busy=0, lasts one cycle.
- start accepted only when busy=0, i.e. in IDLE or DONE. Back-to-back operations are allowed from DONE. start while busy=1 is ignored; there is no queueing.
- On an accepted start edge:
  - working register ← d_in, counter ← shamt, ovf ← 0.
  - shamt==0 → next state DONE; otherwise → SHIFT.
- Each SHIFT edge:
  - ovf ← ovf | (reg[WIDTH-1] ^ reg[WIDTH-2]), evaluated on the pre-shift value.
  - reg ← {reg[WIDTH-2:0],1'b0}.
  - counter ← counter-1.
  - When the pre-decrement counter==1 → DONE; otherwise stay in SHIFT.
- DONE → IDLE on the next edge unless a new start is accepted.
- Latency: done asserts exactly shamt+1 clocks after the accepting edge. Throughput is one operation per shamt+1 cycles.
- d_out is the working register, valid when done=1. It holds unchanged in IDLE/DONE until the next accepted start, and changes every cycle during SHIFT.
- ovf is valid with done and held with d_out.
- shamt ≥ WIDTH is legal: result is 0, and ovf is set if any pre-shift sign/next-bit pair differed.
- Zero-fill on the right only. There is no carry-out port.
- Counter never wraps: decrement occurs only in SHIFT, where counter ≥1.

Decomposition:
- Shared package holds:
  - FSM state encoding as localparams: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - Default WIDTH/SHAMT_W.
- One natural sub-module: shamt_dcnt. It is a loadable down-counter (SHAMT_W bits, async active-low reset, load/dec enables, is_one flag), reusable by the team's counter blocks.
- The FSM and shift register stay in asl8_seq.

Test Plan:
- Reset: hold reset_n=0 mid-clock with start=1 → d_out=0x00, busy=0, done=0, ovf=0; no state change until release.
- d_in=8'h55, shamt=0, start → done one cycle later, busy never high, d_out=8'h55, ovf=0.
- d_in=8'h55, shamt=1 → done 2 cycles after start, d_out=8'hAA, ovf=1 (sign flip).
- d_in=8'hF0, shamt=3 → busy high 3 cycles, done 4 cycles after start, d_out=8'h80, ovf=0. A start pulse during busy is ignored and leaves the result unchanged.
- d_in=8'hAA, shamt=7 → d_out=8'h00, ovf=1, done at cycle 8. Assert start in the DONE cycle with d_in=8'h01, shamt=2 → accepted; done 3 cycles later, d_out=8'h04, ovf=0.
- d_in=8'h13, shamt=5, drop reset_n after 2 SHIFT cycles → outputs clear asynchronously and done is never pulsed. After release, start with d_in=8'h13, shamt=2 → d_out=8'h4C, ovf=0.

Source files
------------

// File: rtl/asl8_seq_pkg.sv
// Shared definitions for the sequential arithmetic shift-left unit:
// FSM state encoding and default datapath widths.
package asl8_seq_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int SHAMT_W_DEF = 3;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/asl8_seq_if.sv
// Start/busy/done handshake bundle between a requester and asl8_seq.
interface asl8_seq_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) ();

  logic               start;
  logic [WIDTH-1:0]   d_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   d_out;
  logic               busy;
  logic               done;
  logic               ovf;

  modport master (output start, d_in, shamt, input d_out, busy, done, ovf);
  modport slave  (input start, d_in, shamt, output d_out, busy, done, ovf);

endinterface

// File: rtl/asl8_seq_shamt_dcnt.sv
// Loadable down-counter with an is_one flag; load has priority over dec
// and dec saturates at zero so the count can never wrap.
module shamt_dcnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         is_one
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (dec && (cnt != '0))   cnt <= cnt - W'(1);
  end

  assign is_one = (cnt == W'(1));

endmodule

// File: rtl/asl8_seq.sv
// Multi-cycle arithmetic shift-left: one bit per clock, signed overflow is
// accumulated from every pre-shift sign/next-bit pair.
module asl8_seq
  import asl8_seq_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  asl8_seq_if.slave   bus
);

  logic [1:0]         state;
  logic [WIDTH-1:0]   sh_reg;
  logic               ovf_r;
  logic [SHAMT_W-1:0] cnt;
  logic               cnt_is_one;
  logic               accept;
  logic               in_shift;

  assign in_shift = (state == ST_SHIFT);
  // DONE counts as not busy, so a new op can chain directly off the pulse
  assign accept   = bus.start && !in_shift;

  shamt_dcnt #(.W(SHAMT_W)) u_dcnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .dec      (in_shift),
    .load_val (bus.shamt),
    .cnt      (cnt),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      sh_reg <= '0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      sh_reg <= bus.d_in;
      ovf_r  <= 1'b0;
      state  <= (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
    end else if (in_shift) begin
      ovf_r  <= ovf_r | (sh_reg[WIDTH-1] ^ sh_reg[WIDTH-2]);
      sh_reg <= {sh_reg[WIDTH-2:0], 1'b0};
      // cnt is never zero here: SHIFT is only entered with a nonzero load
      state  <= (cnt_is_one || (cnt == '0)) ? ST_DONE : ST_SHIFT;
    end else begin
      state  <= ST_IDLE;
    end
  end

  assign bus.d_out = sh_reg;
  assign bus.ovf   = ovf_r;
  assign bus.busy  = in_shift;
  assign bus.done  = (state == ST_DONE);

endmodule

// File: tb/tb_asl8_seq.sv
// Randomized and directed self-checking bench for asl8_seq against a
// signed-arithmetic reference model (repeated doubling with range check).
module tb_asl8_seq;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  asl8_seq_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  asl8_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: shifting left by one is doubling a signed value; a step
  // overflows when the doubled value leaves the 8-bit signed range.
  function automatic void model(input logic [7:0] d, input int s,
                                output logic [7:0] r, output logic o);
    int v;
    logic [7:0] t;
    v = int'($signed(d));
    o = 1'b0;
    for (int i = 0; i < s; i++) begin
      v = v * 2;
      if (v > 127 || v < -128) o = 1'b1;
      t = v[7:0];
      v = int'($signed(t));
    end
    r = v[7:0];
  endfunction

  // Presents one request and runs until done (bounded). poke_at>0 injects
  // a stray start pulse on that edge count while the op is in flight.
  task automatic do_op(input logic [7:0] d, input logic [2:0] s, input int poke_at,
                       output int edges, output int busy_cyc);
    bus.start = 1'b1;
    bus.d_in  = d;
    bus.shamt = s;
    tick();
    edges    = 1;
    busy_cyc = 0;
    bus.start = 1'b0;
    while (!bus.done && edges < 40) begin
      if (bus.busy) busy_cyc++;
      if (edges == poke_at) begin
        bus.start = 1'b1;
        bus.d_in  = 8'h3C;
        bus.shamt = 3'd1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      edges++;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [7:0] d, input logic [2:0] s,
                          input int edges, input int busy_cyc);
    logic [7:0] er;
    logic       eo;
    model(d, int'(s), er, eo);
    checks++;
    if (bus.done !== 1'b1 || edges !== int'(s) + 1) begin
      errors++;
      $display("FAIL %s latency: done=%b edges=%0d required edges=%0d", name, bus.done, edges, s + 1);
    end
    checks++;
    if (busy_cyc !== int'(s)) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cyc, s);
    end
    checks++;
    if (bus.d_out !== er || bus.ovf !== eo) begin
      errors++;
      $display("FAIL %s result: d_out=%h ovf=%b required d_out=%h ovf=%b", name, bus.d_out, bus.ovf, er, eo);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.d_in  = 8'hFF;
    bus.shamt = 3'd3;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.d_out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: d_out=%h busy=%b done=%b ovf=%b required 00/0/0/0",
                 bus.d_out, bus.busy, bus.done, bus.ovf);
      end
    end
    bus.start = 1'b0;
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_shamt0();
    int e, b;
    do_op(8'h55, 3'd0, 0, e, b);
    check_op("shamt0", 8'h55, 3'd0, e, b);
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.d_out !== 8'h55) begin
      errors++;
      $display("FAIL shamt0_hold: done=%b d_out=%h required 0/55", bus.done, bus.d_out);
    end
  endtask

  task automatic test_shamt1();
    int e, b;
    do_op(8'h55, 3'd1, 0, e, b);
    check_op("shamt1", 8'h55, 3'd1, e, b);
    checks++;
    if (bus.d_out !== 8'hAA || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL shamt1_const: d_out=%h ovf=%b required AA/1", bus.d_out, bus.ovf);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int e, b;
    do_op(8'hF0, 3'd3, 2, e, b);
    check_op("busy_ignore", 8'hF0, 3'd3, e, b);
    checks++;
    if (bus.d_out !== 8'h80 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_const: d_out=%h ovf=%b required 80/0", bus.d_out, bus.ovf);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.d_out !== 8'h80) begin
      errors++;
      $display("FAIL busy_ignore_idle: busy=%b done=%b d_out=%h required 0/0/80", bus.busy, bus.done, bus.d_out);
    end
  endtask

  task automatic test_back_to_back();
    int e, b;
    do_op(8'hAA, 3'd7, 0, e, b);
    check_op("b2b_first", 8'hAA, 3'd7, e, b);
    do_op(8'h01, 3'd2, 0, e, b);
    check_op("b2b_second", 8'h01, 3'd2, e, b);
    checks++;
    if (bus.d_out !== 8'h04 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_const: d_out=%h ovf=%b required 04/0", bus.d_out, bus.ovf);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int e, b;
    bit saw_done;
    bus.start = 1'b1;
    bus.d_in  = 8'h13;
    bus.shamt = 3'd5;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.d_out !== 8'h00 || bus.busy !== 1'b0 || bus.ovf !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async_clear: d_out=%h busy=%b ovf=%b done=%b required 00/0/0/0",
               bus.d_out, bus.busy, bus.ovf, bus.done);
    end
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) saw_done = 1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) saw_done = 1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done pulsed=%b required 0", saw_done);
    end
    do_op(8'h13, 3'd2, 0, e, b);
    check_op("after_abort", 8'h13, 3'd2, e, b);
    checks++;
    if (bus.d_out !== 8'h4C || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL after_abort_const: d_out=%h ovf=%b required 4C/0", bus.d_out, bus.ovf);
    end
    tick();
  endtask

  task automatic test_random();
    int e, b;
    logic [7:0] d;
    logic [2:0] s;
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      s = 3'($urandom_range(0, 7));
      do_op(d, s, 0, e, b);
      check_op("random", d, s, e, b);
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.d_in  = '0;
    bus.shamt = '0;
    test_reset();
    test_shamt0();
    test_shamt1();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
